// File: rtl/vmix_mem_pkg.sv
// ---------------------------------------------------------------------------
// vmix_mem_pkg
//   Shared definitions for the frame-buffer writer (wr_mem_line) and the
//   matching readback block. Both sides must agree on the per-mode burst
//   geometry and on the line depth. If they disagree, the readback walks a
//   different layout than the one that was written.
//
//   Contents:
//     MODE_*        encodings of the 2-bit video mode input
//     BRST_LEN_*    words per MCB burst for each mode
//     BRST_NUM_*    bursts per video line for each mode
//     DEPTH_*       visible lines per frame for each mode
//     MCB_WRITE/READ  MCB command opcodes
//     wr_state_e    writer state machine encoding (also shown on debug[2:0])
//     brst_len / brst_num / line_depth  per-mode lookup helpers
// ---------------------------------------------------------------------------
package vmix_mem_pkg;

    localparam logic [1:0] MODE_HMD     = 2'd0;   // 1440x900
    localparam logic [1:0] MODE_XGA     = 2'd1;   // 1024x768
    localparam logic [1:0] MODE_FHD     = 2'd2;   // 1920x1080
    localparam logic [1:0] MODE_INVALID = 2'd3;   // never written

    // One 128-bit word holds 8 RGB565 pixels, so words per line is width/8.
    // The line is then split into four equal bursts.
    localparam logic [5:0] BRST_LEN_HMD = 6'd45;
    localparam logic [5:0] BRST_LEN_XGA = 6'd32;
    localparam logic [5:0] BRST_LEN_FHD = 6'd60;

    localparam logic [2:0] BRST_NUM_HMD = 3'd4;
    localparam logic [2:0] BRST_NUM_XGA = 3'd4;
    localparam logic [2:0] BRST_NUM_FHD = 3'd4;

    localparam logic [10:0] DEPTH_HMD = 11'd900;
    localparam logic [10:0] DEPTH_XGA = 11'd768;
    localparam logic [10:0] DEPTH_FHD = 11'd1080;

    localparam logic [2:0] MCB_WRITE = 3'b000;
    localparam logic [2:0] MCB_READ  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_CMD   = 3'd3,
        ST_DONE  = 3'd4
    } wr_state_e;

    // Words per burst. The invalid mode returns 0. That value is never used,
    // because the writer refuses to start in the invalid mode.
    function automatic logic [5:0] brst_len(input logic [1:0] m);
        case (m)
            MODE_HMD: return BRST_LEN_HMD;
            MODE_XGA: return BRST_LEN_XGA;
            MODE_FHD: return BRST_LEN_FHD;
            default:  return 6'd0;
        endcase
    endfunction

    // Number of bursts in one line.
    function automatic logic [2:0] brst_num(input logic [1:0] m);
        case (m)
            MODE_HMD: return BRST_NUM_HMD;
            MODE_XGA: return BRST_NUM_XGA;
            MODE_FHD: return BRST_NUM_FHD;
            default:  return 3'd0;
        endcase
    endfunction

    // Number of lines per frame. The line counter wraps when it reaches this.
    function automatic logic [10:0] line_depth(input logic [1:0] m);
        case (m)
            MODE_HMD: return DEPTH_HMD;
            MODE_XGA: return DEPTH_XGA;
            MODE_FHD: return DEPTH_FHD;
            default:  return 11'd1;
        endcase
    endfunction

endpackage

// File: rtl/vs_sync_edge.sv
// ---------------------------------------------------------------------------
// vs_sync_edge
//   Brings the asynchronous, active-low vsync into the memclk domain and
//   produces a single-cycle pulse on each falling edge of the synchronised
//   signal.
//
//   Ports:
//     clk_i    memclk
//     rst_i    synchronous active-high reset (all flops cleared)
//     async_i  raw vsync from the capture clock domain
//     fall_o   one-cycle pulse, high when the synchronised vsync went 1->0
// ---------------------------------------------------------------------------
module vs_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-flop synchroniser followed by one history flop for edge detection.
    // Reset clears everything to 0. The first rising edge after reset is
    // therefore harmless, because only falling edges are reported.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/wr_mem_line.sv
// ---------------------------------------------------------------------------
// wr_mem_line
//   Frame-buffer writer. It drains 128-bit pixel words (8 x RGB565) from the
//   FWFT capture FIFO and writes them into DDR, one video line at a time,
//   through a single MCB write port. Each line is sent as a fixed number of
//   bursts. For every burst, the data words are pushed first and the WRITE
//   command is issued afterwards.
//
//   Byte address = {5'd0, frame, line[10:0], col[12:0]}
//
//   Optional build macro:
//     WR_FRAME_FLIP_EN  When defined, the frame bank toggles on every serviced
//                       vsync (double buffering). When undefined, the frame
//                       bank is tied to 0 and vsync only rewinds the line.
//
//   Ports:
//     memclk            sole clock, rising edge
//     rst               synchronous active-high reset
//     mode              0=HMD 1=XGA 2=FHD 3=invalid (no writes)
//     vs                active-low vsync, asynchronous
//     fifo_dout         FWFT data word, valid while ~fifo_empty
//     fifo_empty        upstream FIFO empty
//     fifo_rd_en        pop upstream FIFO (same as mcb_wr_en)
//     memcon_en         arbiter allows one line transfer
//     memcon_donep      line-done, stretched to 5 cycles
//     arb_state         arbiter state; 2'b01 is the write grant
//     mcb_wr_en         MCB write-data push
//     mcb_wr_data       write data (passed straight from fifo_dout)
//     mcb_wr_mask       byte mask, always 0
//     mcb_wr_full       MCB write-data FIFO full
//     mcb_cmd_en        one-cycle command strobe
//     mcb_cmd_instr     always WRITE
//     mcb_cmd_bl        burst length - 1 of the latched mode
//     mcb_cmd_byte_addr registered burst byte address
//     mcb_cmd_full      MCB command FIFO full
//     wr_frame          frame bank currently being written
//     debug             {rd_en, wr_full, empty, cmd_full, 0, state}
// ---------------------------------------------------------------------------
module wr_mem_line
    import vmix_mem_pkg::*;
#(
    parameter int DWIDTH = 128
) (
    input  logic                  memclk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  vs,
    input  logic [DWIDTH-1:0]     fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  memcon_en,
    output logic                  memcon_donep,
    input  logic [1:0]            arb_state,
    output logic                  mcb_wr_en,
    output logic [DWIDTH-1:0]     mcb_wr_data,
    output logic [DWIDTH/8-1:0]   mcb_wr_mask,
    input  logic                  mcb_wr_full,
    output logic                  mcb_cmd_en,
    output logic [2:0]            mcb_cmd_instr,
    output logic [5:0]            mcb_cmd_bl,
    output logic [29:0]           mcb_cmd_byte_addr,
    input  logic                  mcb_cmd_full,
    output logic                  wr_frame,
    output logic [7:0]            debug
);

    wr_state_e   state_q;
    logic [1:0]  mode_q;
    logic [5:0]  cntr_q;
    logic [2:0]  brstcnt_q;
    logic [12:0] col_q;
    logic [10:0] line_q;
    logic        frame_q;
    logic        vs_pend_q;
    logic        memcon_done_q;
    logic [3:0]  done_q;
    logic        cmd_en_q;
    logic [29:0] addr_q;
    logic [5:0]  bl_q;

    logic        vs_fall;
    logic        vs_service;
    logic        start_ok;
    logic        pop;
    logic [5:0]  brst_lim;
    logic [2:0]  brst_cnt_lim;
    logic [10:0] depth;
    logic [12:0] col_step;

    vs_sync_edge u_vs_sync (
        .clk_i   (memclk),
        .rst_i   (rst),
        .async_i (vs),
        .fall_o  (vs_fall)
    );

    // Burst geometry comes from the mode latched at the start of the line.
    // A mode change in the middle of a line therefore only affects the next line.
    assign brst_lim     = brst_len(mode_q);
    assign brst_cnt_lim = brst_num(mode_q);
    assign depth        = line_depth(mode_q);
    assign col_step     = 13'(brst_lim) * 13'(DWIDTH / 8);

    // A pending vsync is only acted on between lines. A line that is already
    // in progress is finished at the address it started with.
    assign vs_service = (state_q == ST_IDLE) && vs_pend_q;

    // Wait for donep to clear before starting again. The arbiter must see
    // this line's done before it grants another line.
    assign start_ok = memcon_en && !memcon_donep && (mode != MODE_INVALID);

    // The pop is combinational. The upstream FIFO and the MCB write FIFO are
    // both FWFT, so a word moves only when both sides are ready and no data
    // is lost while stalled.
    assign pop = (state_q == ST_FILL) && !fifo_empty && !mcb_wr_full && (cntr_q < brst_lim);

    assign fifo_rd_en   = pop;
    assign mcb_wr_en    = pop;
    assign mcb_wr_data  = fifo_dout;
    assign mcb_wr_mask  = '0;

    assign mcb_cmd_en        = cmd_en_q;
    assign mcb_cmd_instr     = MCB_WRITE;
    assign mcb_cmd_bl        = bl_q;
    assign mcb_cmd_byte_addr = addr_q;

    assign memcon_donep = memcon_done_q | (done_q != 4'd0);

`ifdef WR_FRAME_FLIP_EN
    // Double buffering: each serviced vsync moves writing to the other bank.
    // The readback side then reads the bank that was just completed.
    always_ff @(posedge memclk) begin
        if (rst) begin
            frame_q <= 1'b0;
        end else if (vs_service) begin
            frame_q <= ~frame_q;
        end
    end
`else
    assign frame_q = 1'b0;
`endif

    assign wr_frame = frame_q;

    assign debug = {fifo_rd_en, mcb_wr_full, fifo_empty, mcb_cmd_full, 1'b0, state_q};

    // Line-writer state machine.
    //   FILL  moves one burst of data into the MCB.
    //   ISSUE waits for the write grant and for space in the command FIFO.
    //   CMD   advances the column and decides whether the line is finished.
    //   DONE  produces the start of the line-done pulse.
    // The done shift register stretches the pulse to five cycles for the
    // arbiter.
    always_ff @(posedge memclk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= 2'd0;
            cntr_q        <= 6'd0;
            brstcnt_q     <= 3'd0;
            col_q         <= 13'd0;
            line_q        <= 11'd0;
            vs_pend_q     <= 1'b0;
            memcon_done_q <= 1'b0;
            done_q        <= 4'd0;
            cmd_en_q      <= 1'b0;
            addr_q        <= 30'd0;
            bl_q          <= 6'd0;
        end else begin
            done_q <= {done_q[2:0], memcon_done_q};

            if (vs_fall) begin
                vs_pend_q <= 1'b1;
            end else if (vs_service) begin
                vs_pend_q <= 1'b0;
            end

            if (pop) begin
                cntr_q <= cntr_q + 6'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (vs_service) begin
                        line_q <= 11'd0;
                    end
                    if (start_ok) begin
                        mode_q    <= mode;
                        cntr_q    <= 6'd0;
                        brstcnt_q <= 3'd0;
                        col_q     <= 13'd0;
                        state_q   <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    // The comparison uses the count before this cycle's pop.
                    // A full burst is only detected on a cycle with no pop.
                    if (cntr_q == brst_lim) begin
                        state_q <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (!mcb_cmd_full && (arb_state == 2'b01)) begin
                        cmd_en_q <= 1'b1;
                        addr_q   <= {5'd0, frame_q, line_q, col_q};
                        bl_q     <= brst_lim - 6'd1;
                        state_q  <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    cmd_en_q  <= 1'b0;
                    col_q     <= col_q + col_step;
                    brstcnt_q <= brstcnt_q + 3'd1;
                    cntr_q    <= 6'd0;
                    if (brstcnt_q + 3'd1 == brst_cnt_lim) begin
                        // Wrapping without a vsync keeps the same frame bank.
                        line_q        <= (line_q == depth - 11'd1) ? 11'd0 : line_q + 11'd1;
                        memcon_done_q <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        state_q <= ST_FILL;
                    end
                end

                ST_DONE: begin
                    memcon_done_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
